// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: state encoding, one-hot grant
// constants and small decode helpers.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

  // With both requesters valid, the one not served last wins.
  function automatic arb_state_e pick_winner(input logic v0, input logic v1, input logic last);
    if (v0 && (!v1 || last)) begin
      return ST_GNT0;
    end else begin
      return ST_GNT1;
    end
  endfunction

  function automatic logic [1:0] grant_of(input arb_state_e st);
    case (st)
      ST_GNT0: return GRANT_0;
      ST_GNT1: return GRANT_1;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshakes plus the FIFO write port shared by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  fifo_full;
  logic                  fifo_rst_busy;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wdata;

  // Environment side: requesters and the FIFO status flags.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, fifo_full, fifo_rst_busy,
    input  req0_ready, req1_ready, fifo_wr_en, fifo_wdata
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, fifo_full, fifo_rst_busy,
    output req0_ready, req1_ready, fifo_wr_en, fifo_wdata
  );
endinterface

// File: rtl/rst_sync_n.sv
// Active-low reset synchronizer: asserts asynchronously, releases after two
// clock edges so downstream flops leave reset cleanly.
module rst_sync_n (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n_o
);
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d  = {sync_q[0], 1'b1};
  assign rst_n_o = sync_q[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port between two
// requesters, with per-requester accepted-word counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 wr_clk,
  input  logic                 sys_rst_n,
  input  logic                 arb_en,
  fifo_wr_arbiter_if.slave     bus,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  logic                 rst_n_s;
  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]           grant_q, grant_d;
  logic                 stall_s, ready0_s, ready1_s, wr_en_s;
  logic [DATA_WIDTH-1:0] wdata_s;

  rst_sync_n u_rst_sync (
    .clk     (wr_clk),
    .arst_n  (sys_rst_n),
    .rst_n_o (rst_n_s)
  );

  assign stall_s = bus.fifo_full | bus.fifo_rst_busy;

  // Next-state, burst bookkeeping and the combinational write-port mux.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    beat_d   = beat_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    wr_en_s  = 1'b0;
    wdata_s  = '0;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (arb_en && (bus.req0_valid || bus.req1_valid)) begin
          state_d = pick_winner(bus.req0_valid, bus.req1_valid, last_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT0: begin
        ready0_s = ~stall_s;
        wr_en_s  = bus.req0_valid & ~stall_s;
        wdata_s  = bus.req0_data;
        if (wr_en_s) begin
          cnt0_d = cnt0_q + CNT_WIDTH'(1);
          if (beat_q == BEAT_LAST) begin
            last_d  = 1'b0;
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (!bus.req0_valid && !stall_s) begin
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GNT0;
        end
      end
      ST_GNT1: begin
        ready1_s = ~stall_s;
        wr_en_s  = bus.req1_valid & ~stall_s;
        wdata_s  = bus.req1_data;
        if (wr_en_s) begin
          cnt1_d = cnt1_q + CNT_WIDTH'(1);
          if (beat_q == BEAT_LAST) begin
            last_d  = 1'b1;
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (!bus.req1_valid && !stall_s) begin
          last_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GNT1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    grant_d = grant_of(state_d);
  end

  // Arbiter state, burst position and counters.
  always_ff @(posedge wr_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      grant_q <= GRANT_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      grant_q <= grant_d;
    end
  end

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.fifo_wr_en = wr_en_s;
  assign bus.fifo_wdata = wdata_s;
  assign grant          = grant_q;
  assign cnt0           = cnt0_q;
  assign cnt1           = cnt1_q;
endmodule
